drive_sequencer: RTL and testbench

//  Top-level sequencer for the motor_control datapath. Generates the clk_en_tach/clk_en_adc strobes,

---
 rtl/drive_sequencer_if.sv | 25 ++
 rtl/drive_sequencer.sv | 166 ++++++++++++++++
 tb/tb_drive_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/drive_sequencer_if.sv
// drive_sequencer_if: command/feedback inputs and drive/strobe outputs of the drive sequencer.
interface drive_sequencer_if #(
  parameter int RPM_RESOLUTION = 16
);
  logic                      start;
  logic                      stop;
  logic                      fault_clr;
  logic [RPM_RESOLUTION-1:0] target_rpm;
  logic [RPM_RESOLUTION-1:0] rpm_meas_l;
  logic [RPM_RESOLUTION-1:0] rpm_meas_r;
  logic                      clk_en_tach;
  logic                      clk_en_adc;
  logic                      motor_en;
  logic [RPM_RESOLUTION-1:0] base_rpm;
  logic [2:0]                state;
  logic                      fault;
  modport master (
    output start, stop, fault_clr, target_rpm, rpm_meas_l, rpm_meas_r,
    input  clk_en_tach, clk_en_adc, motor_en, base_rpm, state, fault
  );
  modport slave (
    input  start, stop, fault_clr, target_rpm, rpm_meas_l, rpm_meas_r,
    output clk_en_tach, clk_en_adc, motor_en, base_rpm, state, fault
  );
endinterface

// File: rtl/drive_sequencer.sv
// drive_sequencer: strobe generation, soft start/stop slewing of base_rpm and stall fault latching.
module drive_sequencer #(
  parameter int RPM_RESOLUTION = 16,
  parameter int TACH_DIV       = 1_000_000,
  parameter int ADC_DIV        = 100_000,
  parameter int RAMP_STEP      = 4,
  parameter int ARM_TICKS      = 4,
  parameter int STALL_TICKS    = 8,
  parameter int MAX_RPM        = 200
) (
  input logic              clk,
  input logic              reset_n,
  drive_sequencer_if.slave bus
);
  localparam int RW   = RPM_RESOLUTION;
  localparam int TW   = $clog2(TACH_DIV);
  localparam int AW   = $clog2(ADC_DIV);
  localparam int ARMW = $clog2(ARM_TICKS + 1);
  localparam int SW   = $clog2(STALL_TICKS + 1);
  localparam logic [TW-1:0]   TACH_LAST = TW'(TACH_DIV - 1);
  localparam logic [AW-1:0]   ADC_LAST  = AW'(ADC_DIV - 1);
  localparam logic [ARMW-1:0] ARM_LAST  = ARMW'(ARM_TICKS - 1);
  localparam logic [SW-1:0]   STALL_MAX = SW'(STALL_TICKS);
  localparam logic [RW-1:0]   MAX_V     = RW'(MAX_RPM);
  localparam logic [RW-1:0]   STEP_V    = RW'(RAMP_STEP);
  localparam logic [RW-1:0]   BRK_V     = RW'(2 * RAMP_STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    BRAKE = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tach_cnt_q, tach_cnt_d;
  logic [AW-1:0]   adc_cnt_q, adc_cnt_d;
  logic            tach_en_q, tach_en_d;
  logic            adc_en_q, adc_en_d;
  logic [RW-1:0]   base_q, base_d;
  logic            motor_en_q, motor_en_d;
  logic            fault_q, fault_d;
  logic [ARMW-1:0] arm_q, arm_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [RW-1:0]   tgt, up, dn, brk, slew;
  logic [RW:0]     sum;
  logic            meas_zero;

  always_comb begin
    tach_en_d  = tach_cnt_q == TACH_LAST;
    adc_en_d   = adc_cnt_q == ADC_LAST;
    tach_cnt_d = tach_en_d ? '0 : tach_cnt_q + TW'(1);
    adc_cnt_d  = adc_en_d ? '0 : adc_cnt_q + AW'(1);
  end

  // Slew candidates are clamped at tgt/0 so base never wraps or overshoots.
  always_comb begin
    tgt       = (bus.target_rpm > MAX_V) ? MAX_V : bus.target_rpm;
    sum       = {1'b0, base_q} + {1'b0, STEP_V};
    up        = (sum > {1'b0, tgt}) ? tgt : sum[RW-1:0];
    dn        = (base_q - tgt > STEP_V) ? base_q - STEP_V : tgt;
    brk       = (base_q > BRK_V) ? base_q - BRK_V : '0;
    slew      = (base_q < tgt) ? up : (base_q > tgt) ? dn : base_q;
    meas_zero = (bus.rpm_meas_l == '0) || (bus.rpm_meas_r == '0);
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    motor_en_d = motor_en_q;
    fault_d    = fault_q;
    arm_d      = '0;
    stall_d    = '0;
    case (state_q)
      IDLE: begin
        base_d     = '0;
        motor_en_d = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d    = ARM;
          motor_en_d = 1'b1;
        end
      end
      ARM: begin
        base_d = '0;
        arm_d  = arm_q;
        if (bus.stop) state_d = BRAKE;
        else if (adc_en_q) begin
          arm_d   = arm_q + ARMW'(1);
          state_d = (arm_q == ARM_LAST) ? RAMP : ARM;
        end
      end
      RAMP: begin
        if (bus.stop) state_d = BRAKE;
        else if (base_q == tgt) state_d = RUN;
        else if (adc_en_q) base_d = slew;
      end
      RUN: begin
        if (stall_q == STALL_MAX) begin
          state_d    = FAULT;
          base_d     = '0;
          motor_en_d = 1'b0;
          fault_d    = 1'b1;
        end else if (bus.stop || !bus.start) state_d = BRAKE;
        else begin
          stall_d = tach_en_q ? (meas_zero ? stall_q + SW'(1) : '0) : stall_q;
          if (adc_en_q) base_d = slew;
        end
      end
      BRAKE: begin
        if (base_q == '0) begin
          state_d    = IDLE;
          motor_en_d = 1'b0;
        end else if (adc_en_q) base_d = brk;
      end
      FAULT: begin
        base_d     = '0;
        motor_en_d = 1'b0;
        fault_d    = 1'b1;
        if (bus.fault_clr && !bus.start) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        base_d     = '0;
        motor_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tach_cnt_q <= '0;
      adc_cnt_q  <= '0;
      tach_en_q  <= 1'b0;
      adc_en_q   <= 1'b0;
      base_q     <= '0;
      motor_en_q <= 1'b0;
      fault_q    <= 1'b0;
      arm_q      <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      tach_cnt_q <= tach_cnt_d;
      adc_cnt_q  <= adc_cnt_d;
      tach_en_q  <= tach_en_d;
      adc_en_q   <= adc_en_d;
      base_q     <= base_d;
      motor_en_q <= motor_en_d;
      fault_q    <= fault_d;
      arm_q      <= arm_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.clk_en_tach = tach_en_q;
  assign bus.clk_en_adc  = adc_en_q;
  assign bus.motor_en    = motor_en_q;
  assign bus.base_rpm    = base_q;
  assign bus.state       = state_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: scenario tasks with a base_rpm scoreboard for the drive sequencer.
module tb_drive_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  drive_sequencer_if #(.RPM_RESOLUTION(16)) bus();

  drive_sequencer #(
    .RPM_RESOLUTION(16), .TACH_DIV(10), .ADC_DIV(4), .RAMP_STEP(4),
    .ARM_TICKS(2), .STALL_TICKS(3), .MAX_RPM(200)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    bus.start = 0; bus.stop = 0; bus.fault_clr = 0;
    bus.target_rpm = 0; bus.rpm_meas_l = 50; bus.rpm_meas_r = 50;
    reset_n = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd0 || bus.base_rpm !== 16'd0 || bus.motor_en !== 1'b0 || bus.fault !== 1'b0 ||
        bus.clk_en_adc !== 1'b0 || bus.clk_en_tach !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d base=%0d en=%b fault=%b adc=%b tach=%b, required all 0",
               bus.state, bus.base_rpm, bus.motor_en, bus.fault, bus.clk_en_adc, bus.clk_en_tach);
    end
    reset_n = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.clk_en_adc !== (k % 4 == 0) || bus.clk_en_tach !== (k % 10 == 0) || bus.state !== 3'd0) begin
        n_fail++;
        $display("FAIL strobes cycle %0d: adc=%b tach=%b state=%0d, required adc=%b tach=%b state=0",
                 k, bus.clk_en_adc, bus.clk_en_tach, bus.state, k % 4 == 0, k % 10 == 0);
      end
    end
  endtask

  task automatic test_ramp();
    logic [15:0] prev, exp_v;
    int arm_strobes = 0;
    bus.start = 1; bus.target_rpm = 20;
    for (int v = 4; v <= 20; v += 4) exp_q.push_back(16'(v));
    prev = bus.base_rpm;
    @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd1 || bus.motor_en !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_entry: state=%0d en=%b, required state=1 en=1", bus.state, bus.motor_en);
    end
    for (int c = 0; c < 200 && bus.state !== 3'd3; c++) begin
      if (bus.state === 3'd1 && bus.clk_en_adc === 1'b1) arm_strobes++;
      @(negedge clk);
      if (bus.base_rpm !== prev) begin
        exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 16'hFFFF;
        n_checks++;
        if (bus.base_rpm !== exp_v) begin
          n_fail++;
          $display("FAIL ramp_step: base=%0d, required %0d", bus.base_rpm, exp_v);
        end
        prev = bus.base_rpm;
      end
    end
    n_checks++;
    if (bus.state !== 3'd3 || bus.base_rpm !== 16'd20 || exp_q.size() != 0 || arm_strobes != 2) begin
      n_fail++;
      $display("FAIL ramp_done: state=%0d base=%0d left=%0d arm_strobes=%0d, required state=3 base=20 left=0 arm_strobes=2",
               bus.state, bus.base_rpm, exp_q.size(), arm_strobes);
      exp_q.delete();
    end
  endtask

  task automatic test_max_clamp();
    logic [15:0] prev, exp_v;
    bus.target_rpm = 300;
    for (int v = 24; v <= 200; v += 4) exp_q.push_back(16'(v));
    prev = bus.base_rpm;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (bus.base_rpm !== prev) begin
        exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 16'hFFFF;
        n_checks++;
        if (bus.base_rpm !== exp_v) begin
          n_fail++;
          $display("FAIL clamp_step: base=%0d, required %0d", bus.base_rpm, exp_v);
        end
        prev = bus.base_rpm;
      end
    end
    n_checks++;
    if (bus.base_rpm !== 16'd200 || bus.state !== 3'd3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clamp_final: base=%0d state=%0d left=%0d, required base=200 state=3 left=0",
               bus.base_rpm, bus.state, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stop_brake();
    logic [15:0] prev, exp_v;
    bus.target_rpm = 20;
    for (int c = 0; c < 400 && bus.base_rpm !== 16'd20; c++) @(negedge clk);
    n_checks++;
    if (bus.base_rpm !== 16'd20 || bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL slew_down: base=%0d state=%0d, required base=20 state=3", bus.base_rpm, bus.state);
    end
    bus.stop = 1;
    exp_q.push_back(16'd12); exp_q.push_back(16'd4); exp_q.push_back(16'd0);
    prev = bus.base_rpm;
    @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd4 || bus.motor_en !== 1'b1) begin
      n_fail++;
      $display("FAIL brake_entry: state=%0d en=%b, required state=4 en=1", bus.state, bus.motor_en);
    end
    for (int c = 0; c < 100 && bus.state !== 3'd0; c++) begin
      @(negedge clk);
      if (bus.base_rpm !== prev) begin
        exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 16'hFFFF;
        n_checks++;
        if (bus.base_rpm !== exp_v) begin
          n_fail++;
          $display("FAIL brake_step: base=%0d, required %0d", bus.base_rpm, exp_v);
        end
        prev = bus.base_rpm;
      end
    end
    n_checks++;
    if (bus.state !== 3'd0 || bus.motor_en !== 1'b0 || bus.base_rpm !== 16'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL brake_idle: state=%0d en=%b base=%0d left=%0d, required state=0 en=0 base=0 left=0",
               bus.state, bus.motor_en, bus.base_rpm, exp_q.size());
      exp_q.delete();
    end
    bus.stop = 0;
  endtask

  task automatic test_stall_fault();
    bit braked = 0;
    for (int c = 0; c < 200 && bus.state !== 3'd3; c++) @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL rerun: state=%0d, required 3", bus.state);
    end
    bus.rpm_meas_l = 0;
    for (int c = 0; c < 80 && bus.state !== 3'd5; c++) begin
      @(negedge clk);
      if (bus.state === 3'd4) braked = 1;
    end
    n_checks++;
    if (bus.state !== 3'd5 || bus.fault !== 1'b1 || bus.base_rpm !== 16'd0 || bus.motor_en !== 1'b0 || braked) begin
      n_fail++;
      $display("FAIL stall: state=%0d fault=%b base=%0d en=%b braked=%b, required state=5 fault=1 base=0 en=0 braked=0",
               bus.state, bus.fault, bus.base_rpm, bus.motor_en, braked);
    end
    bus.fault_clr = 1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd5 || bus.fault !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_start: state=%0d fault=%b, required state=5 fault=1", bus.state, bus.fault);
    end
    bus.start = 0;
    @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL clr: state=%0d fault=%b, required state=0 fault=0", bus.state, bus.fault);
    end
    bus.fault_clr = 0; bus.rpm_meas_l = 50;
  endtask

  task automatic test_reset_mid_ramp();
    bus.start = 1; bus.target_rpm = 100;
    for (int c = 0; c < 200 && !(bus.state === 3'd2 && bus.base_rpm === 16'd8); c++) @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd2 || bus.base_rpm !== 16'd8) begin
      n_fail++;
      $display("FAIL mid_ramp_reach: state=%0d base=%0d, required state=2 base=8", bus.state, bus.base_rpm);
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if (bus.state !== 3'd0 || bus.base_rpm !== 16'd0 || bus.motor_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d base=%0d en=%b, required 0 0 0", bus.state, bus.base_rpm, bus.motor_en);
    end
    @(negedge clk);
    bus.start = 0;
    reset_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_max_clamp();
    test_stop_brake();
    test_stall_fault();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
